window_scan_sequencer: RTL and testbench

Sequences a sliding-window scan over a stored image for the convolution datapath. After a start request it walks every window origin, and every tap inside each window, in raster order. For each tap it emits a flat pixel address to the feature-map memory over a valid/ready handshake, then reports completion with a single done pulse. Stride is fixed at 1 and there is no padding.

---
 rtl/window_scan_sequencer_if.sv | 50 +++++
 rtl/window_scan_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_window_scan_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/window_scan_sequencer_if.sv
// ---------------------------------------------------------------------------
// window_scan_sequencer_if
//   Bundles the control inputs and the tap-address stream of the window scan
//   sequencer.
//   master : the sequencer (drives the tap stream, receives start/config)
//   slave  : the controller / feature-map consumer side
//   Signals:
//     start_i, abort_i        scan control
//     img_w_i, img_h_i, win_i image width/height and window size
//     valid_o, ready_i        tap handshake
//     addr_o                  flat pixel address of the current tap
//     row_o, col_o            window origin
//     krow_o, kcol_o          tap offset inside the window
//     win_last_o, scan_last_o last tap of window / of scan
//     busy_o, done_o, err_o   status
// ---------------------------------------------------------------------------
interface window_scan_sequencer_if #(
    parameter int DimBits  = 8,
    parameter int AddrBits = 16
);
    logic                start_i;
    logic                abort_i;
    logic [DimBits-1:0]  img_w_i;
    logic [DimBits-1:0]  img_h_i;
    logic [DimBits-1:0]  win_i;
    logic                valid_o;
    logic                ready_i;
    logic [AddrBits-1:0] addr_o;
    logic [DimBits-1:0]  row_o;
    logic [DimBits-1:0]  col_o;
    logic [DimBits-1:0]  krow_o;
    logic [DimBits-1:0]  kcol_o;
    logic                win_last_o;
    logic                scan_last_o;
    logic                busy_o;
    logic                done_o;
    logic                err_o;

    modport master (
        input  start_i, abort_i, img_w_i, img_h_i, win_i, ready_i,
        output valid_o, addr_o, row_o, col_o, krow_o, kcol_o,
               win_last_o, scan_last_o, busy_o, done_o, err_o
    );

    modport slave (
        output start_i, abort_i, img_w_i, img_h_i, win_i, ready_i,
        input  valid_o, addr_o, row_o, col_o, krow_o, kcol_o,
               win_last_o, scan_last_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/window_scan_sequencer.sv
// ---------------------------------------------------------------------------
// window_scan_sequencer
//   Walks every KxK window origin (stride 1, no padding) of a WxH image and
//   every tap inside each window in raster order, emitting one flat pixel
//   address per tap over valid/ready, then a one-cycle done pulse.
//   Ports:
//     clk_i  clock
//     rst_i  asynchronous active-high reset
//     bus    window_scan_sequencer_if.master (control, config, tap stream)
//   Optional: define WINDOW_SCAN_SEQUENCER_ASSERT_EN to compile in simulation
//   assertions (handshake stability, address formula, done width, params).
// ---------------------------------------------------------------------------
module window_scan_sequencer #(
    parameter int DimBits  = 8,
    parameter int AddrBits = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    window_scan_sequencer_if.master    bus
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t              state;
    logic [DimBits-1:0]  img_w, img_h, win;
    // origin_base = row*W, row_base = (row+krow)*W; both kept incrementally
    // so the address path needs only adders.
    logic [AddrBits-1:0] origin_base, row_base;

    logic                cfg_ok;
    logic [DimBits-1:0]  w_eff, h_eff, k_eff, k_m1;
    logic [AddrBits-1:0] w_ext, col_ext;
    logic [DimBits-1:0]  n_row, n_col, n_krow, n_kcol;
    logic [AddrBits-1:0] n_addr, n_row_base, n_origin;
    logic                n_win_last, n_scan_last;

    assign cfg_ok = (bus.win_i != '0) && (bus.win_i <= bus.img_w_i) &&
                    (bus.win_i <= bus.img_h_i);

    // Next tap position; in IDLE it is the first tap of a scan using the live
    // config inputs so the flags are correct in the very first SCAN cycle.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch
        // is inferred on paths that do not assign it.
        w_eff       = (state == IDLE) ? bus.img_w_i : img_w;
        h_eff       = (state == IDLE) ? bus.img_h_i : img_h;
        k_eff       = (state == IDLE) ? bus.win_i   : win;
        k_m1        = k_eff - 1'b1;
        w_ext       = AddrBits'(img_w);
        col_ext     = AddrBits'(bus.col_o);
        n_row       = bus.row_o;
        n_col       = bus.col_o;
        n_krow      = bus.krow_o;
        n_kcol      = bus.kcol_o;
        n_addr      = bus.addr_o;
        n_row_base  = row_base;
        n_origin    = origin_base;
        if (state == IDLE) begin
            n_row      = '0;
            n_col      = '0;
            n_krow     = '0;
            n_kcol     = '0;
            n_addr     = '0;
            n_row_base = '0;
            n_origin   = '0;
        end else if (bus.kcol_o != k_m1) begin
            n_kcol = bus.kcol_o + 1'b1;
            n_addr = bus.addr_o + 1'b1;
        end else if (bus.krow_o != k_m1) begin
            n_kcol     = '0;
            n_krow     = bus.krow_o + 1'b1;
            n_row_base = row_base + w_ext;
            n_addr     = row_base + w_ext + col_ext;
        end else if (bus.col_o != DimBits'(img_w - win)) begin
            n_kcol     = '0;
            n_krow     = '0;
            n_col      = bus.col_o + 1'b1;
            n_row_base = origin_base;
            n_addr     = origin_base + col_ext + 1'b1;
        end else begin
            n_kcol     = '0;
            n_krow     = '0;
            n_col      = '0;
            n_row      = bus.row_o + 1'b1;
            n_origin   = origin_base + w_ext;
            n_row_base = origin_base + w_ext;
            n_addr     = origin_base + w_ext;
        end
        n_win_last  = (n_krow == k_m1) && (n_kcol == k_m1);
        n_scan_last = n_win_last && (n_col == DimBits'(w_eff - k_eff)) &&
                      (n_row == DimBits'(h_eff - k_eff));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst_i) begin
            state            <= IDLE;
            img_w            <= '0;
            img_h            <= '0;
            win              <= '0;
            origin_base      <= '0;
            row_base         <= '0;
            bus.valid_o      <= 1'b0;
            bus.addr_o       <= '0;
            bus.row_o        <= '0;
            bus.col_o        <= '0;
            bus.krow_o       <= '0;
            bus.kcol_o       <= '0;
            bus.win_last_o   <= 1'b0;
            bus.scan_last_o  <= 1'b0;
            bus.busy_o       <= 1'b0;
            bus.done_o       <= 1'b0;
            bus.err_o        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done_o <= 1'b0;
                    if (bus.start_i) begin
                        img_w <= bus.img_w_i;
                        img_h <= bus.img_h_i;
                        win   <= bus.win_i;
                        if (cfg_ok) begin
                            state           <= SCAN;
                            bus.err_o       <= 1'b0;
                            bus.valid_o     <= 1'b1;
                            bus.busy_o      <= 1'b1;
                            bus.addr_o      <= n_addr;
                            bus.row_o       <= n_row;
                            bus.col_o       <= n_col;
                            bus.krow_o      <= n_krow;
                            bus.kcol_o      <= n_kcol;
                            row_base        <= n_row_base;
                            origin_base     <= n_origin;
                            bus.win_last_o  <= n_win_last;
                            bus.scan_last_o <= n_scan_last;
                        end else begin
                            state      <= DONE;
                            bus.err_o  <= 1'b1;
                            bus.done_o <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    // Abort wins over a simultaneous transfer; the final
                    // transfer ends the scan. Both clear the tap outputs.
                    if (bus.abort_i || (bus.ready_i && bus.scan_last_o)) begin
                        state           <= bus.abort_i ? IDLE : DONE;
                        bus.done_o      <= !bus.abort_i;
                        bus.valid_o     <= 1'b0;
                        bus.busy_o      <= 1'b0;
                        bus.addr_o      <= '0;
                        bus.row_o       <= '0;
                        bus.col_o       <= '0;
                        bus.krow_o      <= '0;
                        bus.kcol_o      <= '0;
                        row_base        <= '0;
                        origin_base     <= '0;
                        bus.win_last_o  <= 1'b0;
                        bus.scan_last_o <= 1'b0;
                    end else if (bus.ready_i) begin
                        bus.addr_o      <= n_addr;
                        bus.row_o       <= n_row;
                        bus.col_o       <= n_col;
                        bus.krow_o      <= n_krow;
                        bus.kcol_o      <= n_kcol;
                        row_base        <= n_row_base;
                        origin_base     <= n_origin;
                        bus.win_last_o  <= n_win_last;
                        bus.scan_last_o <= n_scan_last;
                    end
                end
                DONE: begin
                    bus.done_o <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WINDOW_SCAN_SEQUENCER_ASSERT_EN
    a_params: assert property (@(posedge clk_i) AddrBits >= 2 * DimBits);

    a_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (bus.valid_o && !bus.ready_i && !bus.abort_i) |=>
        ($stable(bus.addr_o) && $stable(bus.row_o) && $stable(bus.col_o) &&
         $stable(bus.krow_o) && $stable(bus.kcol_o) && $stable(bus.valid_o) &&
         $stable(bus.win_last_o) && $stable(bus.scan_last_o)));

    a_addr: assert property (@(posedge clk_i) disable iff (rst_i)
        bus.valid_o |-> (bus.addr_o ==
            AddrBits'((AddrBits'(bus.row_o) + AddrBits'(bus.krow_o)) * AddrBits'(img_w) +
                      AddrBits'(bus.col_o) + AddrBits'(bus.kcol_o))));

    a_done: assert property (@(posedge clk_i) disable iff (rst_i)
        bus.done_o |=> !bus.done_o);
`endif

endmodule

// File: tb/tb_window_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_window_scan_sequencer
//   Directed self-checking bench for window_scan_sequencer. Inputs change on
//   the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_window_scan_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [15:0] got[$];

    always #5 clk = ~clk;

    window_scan_sequencer_if #(.DimBits(8), .AddrBits(16)) bus ();

    window_scan_sequencer #(.DimBits(8), .AddrBits(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic test_reset();
        bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.ready_i = 1'b0;
        bus.img_w_i = '0; bus.img_h_i = '0; bus.win_i = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.valid_o, bus.busy_o, bus.done_o, bus.err_o, bus.addr_o, bus.win_last_o, bus.scan_last_o} !== '0)
            begin n_bad++; $display("FAIL reset_outputs: got v%b b%b d%b e%b a%0d, want all 0",
                bus.valid_o, bus.busy_o, bus.done_o, bus.err_o, bus.addr_o); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.valid_o, bus.busy_o, bus.done_o} !== 3'b000)
            begin n_bad++; $display("FAIL reset_idle: got v%b b%b d%b, want 000", bus.valid_o, bus.busy_o, bus.done_o); end
    endtask

    // Runs a full scan, comparing every tap against the address formula.
    task automatic run_scan(input int w, input int h, input int k, input bit toggle,
                            input string name, output int n_xfer, output int n_wl);
        logic [15:0] ea;
        logic [7:0]  er, ec, ekr, ekc;
        logic        ewl, esl;
        n_xfer = 0; n_wl = 0;
        got.delete();
        bus.img_w_i = 8'(w); bus.img_h_i = 8'(h); bus.win_i = 8'(k);
        bus.ready_i = !toggle;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.img_w_i = 8'd9; bus.img_h_i = 8'd9; bus.win_i = 8'd7;  // must be ignored
        n_cmp++;
        if (bus.err_o !== 1'b0)
            begin n_bad++; $display("FAIL %s_err_clear: got %b want 0", name, bus.err_o); end
        for (int r = 0; r <= h - k; r++)
            for (int c = 0; c <= w - k; c++)
                for (int kr = 0; kr < k; kr++)
                    for (int kc = 0; kc < k; kc++) begin
                        ea  = 16'((r + kr) * w + c + kc);
                        er  = 8'(r); ec = 8'(c); ekr = 8'(kr); ekc = 8'(kc);
                        ewl = (kr == k - 1) && (kc == k - 1);
                        esl = ewl && (r == h - k) && (c == w - k);
                        for (int pass = 0; pass < (toggle ? 2 : 1); pass++) begin
                            if (pass == 0) got.push_back(bus.addr_o);
                            n_cmp++;
                            if (bus.addr_o !== ea)
                                begin n_bad++; $display("FAIL %s_addr[%0d]: got %0d want %0d", name, n_xfer, bus.addr_o, ea); end
                            n_cmp++;
                            if ({bus.valid_o, bus.busy_o, bus.row_o, bus.col_o, bus.krow_o, bus.kcol_o, bus.win_last_o, bus.scan_last_o}
                                !== {2'b11, er, ec, ekr, ekc, ewl, esl})
                                begin n_bad++; $display("FAIL %s_tap[%0d]: got v%b b%b r%0d c%0d kr%0d kc%0d wl%b sl%b want 11 r%0d c%0d kr%0d kc%0d wl%b sl%b",
                                    name, n_xfer, bus.valid_o, bus.busy_o, bus.row_o, bus.col_o, bus.krow_o, bus.kcol_o,
                                    bus.win_last_o, bus.scan_last_o, er, ec, ekr, ekc, ewl, esl); end
                            if (pass == 0 && toggle) begin
                                bus.ready_i = 1'b0;
                                @(negedge clk);
                            end
                        end
                        if (bus.win_last_o) n_wl++;
                        n_xfer++;
                        bus.ready_i = 1'b1;
                        @(negedge clk);
                    end
        n_cmp++;
        if ({bus.done_o, bus.busy_o, bus.valid_o} !== 3'b100)
            begin n_bad++; $display("FAIL %s_done: got d%b b%b v%b want 100", name, bus.done_o, bus.busy_o, bus.valid_o); end
        @(negedge clk);
        n_cmp++;
        if ({bus.done_o, bus.busy_o, bus.valid_o} !== 3'b000)
            begin n_bad++; $display("FAIL %s_done_single: got d%b b%b v%b want 000", name, bus.done_o, bus.busy_o, bus.valid_o); end
        bus.ready_i = 1'b0;
    endtask

    task automatic test_basic();
        int nx, nw;
        logic [15:0] first_win [9] = '{16'd0, 16'd1, 16'd2, 16'd4, 16'd5, 16'd6, 16'd8, 16'd9, 16'd10};
        run_scan(4, 4, 3, 1'b0, "basic", nx, nw);
        n_cmp++;
        if (nx !== 36) begin n_bad++; $display("FAIL basic_count: got %0d want 36", nx); end
        for (int i = 0; i < 9 && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== first_win[i])
                begin n_bad++; $display("FAIL basic_first_win[%0d]: got %0d want %0d", i, got[i], first_win[i]); end
        end
        n_cmp++;
        if (got.size() != 36 || got[got.size()-1] !== 16'd15)
            begin n_bad++; $display("FAIL basic_last_addr: got size %0d, want last 15", got.size()); end
    endtask

    task automatic test_backpressure();
        int nx, nw;
        run_scan(4, 4, 3, 1'b1, "bp", nx, nw);
        n_cmp++;
        if (nx !== 36) begin n_bad++; $display("FAIL bp_count: got %0d want 36", nx); end
    endtask

    task automatic test_window_boundary();
        int nx, nw;
        run_scan(5, 3, 2, 1'b0, "wb", nx, nw);
        n_cmp++;
        if (nx !== 32) begin n_bad++; $display("FAIL wb_count: got %0d want 32", nx); end
        n_cmp++;
        if (nw !== 8) begin n_bad++; $display("FAIL wb_windows: got %0d want 8", nw); end
        n_cmp++;
        if (got.size() != 32 || got[3] !== 16'd6 || got[31] !== 16'd14)
            begin n_bad++; $display("FAIL wb_addrs: got size %0d, want [3]=6 [31]=14", got.size()); end
    endtask

    task automatic test_invalid();
        int nx, nw;
        bus.img_w_i = 8'd4; bus.img_h_i = 8'd4; bus.win_i = 8'd5; bus.ready_i = 1'b1;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        n_cmp++;
        if ({bus.err_o, bus.done_o, bus.valid_o, bus.busy_o} !== 4'b1100)
            begin n_bad++; $display("FAIL inv_pulse: got e%b d%b v%b b%b want 1100", bus.err_o, bus.done_o, bus.valid_o, bus.busy_o); end
        @(negedge clk);
        n_cmp++;
        if ({bus.err_o, bus.done_o, bus.valid_o} !== 3'b100)
            begin n_bad++; $display("FAIL inv_after: got e%b d%b v%b want 100", bus.err_o, bus.done_o, bus.valid_o); end
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.err_o, bus.valid_o} !== 2'b10)
            begin n_bad++; $display("FAIL inv_sticky: got e%b v%b want 10", bus.err_o, bus.valid_o); end
        bus.ready_i = 1'b0;
        run_scan(2, 2, 2, 1'b0, "inv_recover", nx, nw);
        n_cmp++;
        if (nx !== 4) begin n_bad++; $display("FAIL inv_recover_count: got %0d want 4", nx); end
    endtask

    task automatic test_abort();
        bus.img_w_i = 8'd4; bus.img_h_i = 8'd4; bus.win_i = 8'd3; bus.ready_i = 1'b1;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (9) @(negedge clk);
        n_cmp++;
        if ({bus.valid_o, bus.addr_o, bus.col_o} !== {1'b1, 16'd1, 8'd1})
            begin n_bad++; $display("FAIL abort_tap10: got v%b a%0d c%0d want v1 a1 c1", bus.valid_o, bus.addr_o, bus.col_o); end
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        n_cmp++;
        if ({bus.valid_o, bus.busy_o, bus.done_o} !== 3'b000)
            begin n_bad++; $display("FAIL abort_idle: got v%b b%b d%b want 000", bus.valid_o, bus.busy_o, bus.done_o); end
        @(negedge clk);
        n_cmp++;
        if (bus.done_o !== 1'b0) begin n_bad++; $display("FAIL abort_no_done: got %b want 0", bus.done_o); end
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        n_cmp++;
        if ({bus.valid_o, bus.addr_o, bus.col_o} !== {1'b1, 16'd0, 8'd0})
            begin n_bad++; $display("FAIL abort_restart: got v%b a%0d c%0d want v1 a0 c0", bus.valid_o, bus.addr_o, bus.col_o); end
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        bus.ready_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        bus.img_w_i = 8'd4; bus.img_h_i = 8'd4; bus.win_i = 8'd3; bus.ready_i = 1'b1;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({bus.valid_o, bus.addr_o, bus.krow_o} !== {1'b1, 16'd5, 8'd1})
            begin n_bad++; $display("FAIL arst_pre: got v%b a%0d kr%0d want v1 a5 kr1", bus.valid_o, bus.addr_o, bus.krow_o); end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.valid_o, bus.busy_o, bus.addr_o, bus.krow_o, bus.kcol_o, bus.row_o, bus.col_o} !== '0)
            begin n_bad++; $display("FAIL arst_immediate: got v%b b%b a%0d kr%0d want all 0", bus.valid_o, bus.busy_o, bus.addr_o, bus.krow_o); end
        bus.ready_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_degenerate();
        bus.img_w_i = 8'd1; bus.img_h_i = 8'd1; bus.win_i = 8'd1; bus.ready_i = 1'b1;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        n_cmp++;
        if ({bus.valid_o, bus.addr_o, bus.win_last_o, bus.scan_last_o} !== {1'b1, 16'd0, 2'b11})
            begin n_bad++; $display("FAIL deg_tap: got v%b a%0d wl%b sl%b want v1 a0 wl1 sl1", bus.valid_o, bus.addr_o, bus.win_last_o, bus.scan_last_o); end
        @(negedge clk);
        n_cmp++;
        if ({bus.done_o, bus.valid_o} !== 2'b10)
            begin n_bad++; $display("FAIL deg_done: got d%b v%b want 10", bus.done_o, bus.valid_o); end
        bus.img_w_i = 8'd4; bus.img_h_i = 8'd4; bus.win_i = 8'd3;
        bus.start_i = 1'b1;  // lands in DONE, must be ignored
        @(negedge clk);
        bus.start_i = 1'b0;
        n_cmp++;
        if ({bus.valid_o, bus.busy_o, bus.done_o} !== 3'b000)
            begin n_bad++; $display("FAIL deg_start_in_done: got v%b b%b d%b want 000", bus.valid_o, bus.busy_o, bus.done_o); end
        @(negedge clk);
        n_cmp++;
        if ({bus.valid_o, bus.busy_o} !== 2'b00)
            begin n_bad++; $display("FAIL deg_stays_idle: got v%b b%b want 00", bus.valid_o, bus.busy_o); end
        bus.ready_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_window_boundary();
        test_invalid();
        test_abort();
        test_async_reset();
        test_degenerate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
